// File: rtl/tsn_tx_frame_arbiter_if.sv
// AXI-Stream bundle between the traffic-class queues and the MAC TX client FIFO.
// The arbiter uses the slave modport; the queue/FIFO side uses master.
interface tsn_tx_frame_arbiter_if #(
  parameter int NUM_QUEUES = 4
);
  logic [8*NUM_QUEUES-1:0] s_axis_tdata;
  logic [NUM_QUEUES-1:0]   s_axis_tvalid;
  logic [NUM_QUEUES-1:0]   s_axis_tlast;
  logic [NUM_QUEUES-1:0]   s_axis_tready;
  logic [7:0]              m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tlast;
  logic                    m_axis_tuser;
  logic                    m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready
  );
endinterface

// File: rtl/tsn_tx_frame_arbiter.sv
// Frame-atomic arbiter sharing the byte-wide TX client path between gated queues,
// with strict-priority or round-robin selection and max-length truncation.
module tsn_tx_frame_arbiter #(
  parameter int NUM_QUEUES    = 4,
  parameter int MAX_FRAME_LEN = 1522,
  parameter int CNT_W         = 11
) (
  input  logic                  tx_mac_aclk,
  input  logic                  tx_mac_resetn,
  tsn_tx_frame_arbiter_if.slave axis,
  input  logic [NUM_QUEUES-1:0] gate_open,
  input  logic                  arb_mode,
  output logic [2:0]            grant_q,
  output logic                  busy,
  output logic                  trunc_pulse
);

  localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [QW-1:0]         grant_reg, grant_next;
  logic [QW-1:0]         rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]      byte_cnt_reg, byte_cnt_next;
  logic                  trunc_reg, trunc_next;
  logic [QW-1:0]         pick;
  logic [QW-1:0]         grant_inc;
  logic [NUM_QUEUES-1:0] req;
  logic [7:0]            q_data [NUM_QUEUES];
  logic                  sel_valid, sel_last, force_last, out_beat;
  int                    idx;

  for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_lane
    assign q_data[gi] = axis.s_axis_tdata[8*gi +: 8];
  end

  assign req        = axis.s_axis_tvalid & gate_open;
  assign sel_valid  = axis.s_axis_tvalid[grant_reg];
  assign sel_last   = axis.s_axis_tlast[grant_reg];
  assign force_last = (byte_cnt_reg == CNT_W'(MAX_FRAME_LEN - 1));
  assign grant_inc  = (grant_reg == QW'(NUM_QUEUES - 1)) ? '0 : grant_reg + QW'(1);

  // Later loop iterations override earlier ones: strict keeps the highest
  // index, round-robin keeps the smallest distance from rr_ptr.
  always_comb begin
    pick = '0;
    idx  = 0;
    if (!arb_mode) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (req[QW'(q)]) pick = QW'(q);
      end
    end else begin
      for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_reg) + k;
        if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
        if (req[QW'(idx)]) pick = QW'(idx);
      end
    end
  end

  always_comb begin
    state_next         = state_reg;
    grant_next         = grant_reg;
    rr_ptr_next        = rr_ptr_reg;
    byte_cnt_next      = byte_cnt_reg;
    trunc_next         = 1'b0;
    out_beat           = 1'b0;
    axis.s_axis_tready = '0;
    axis.m_axis_tdata  = 8'h00;
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tlast  = 1'b0;
    axis.m_axis_tuser  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          grant_next    = pick;
          byte_cnt_next = '0;
          state_next    = XFER;
        end
      end
      XFER: begin
        axis.m_axis_tdata             = q_data[grant_reg];
        axis.m_axis_tvalid            = sel_valid;
        axis.m_axis_tlast             = sel_last | force_last;
        axis.m_axis_tuser             = force_last & ~sel_last;
        axis.s_axis_tready[grant_reg] = axis.m_axis_tready;
        out_beat                      = sel_valid & axis.m_axis_tready;
        if (out_beat) begin
          byte_cnt_next = byte_cnt_reg + CNT_W'(1);
          if (sel_last) begin
            rr_ptr_next = grant_inc;
            state_next  = IDLE;
          end else if (force_last) begin
            rr_ptr_next = grant_inc;
            trunc_next  = 1'b1;
            state_next  = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Swallow the oversize tail; nothing reaches the FIFO.
        axis.s_axis_tready[grant_reg] = 1'b1;
        if (sel_valid && sel_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
    if (!tx_mac_resetn) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      byte_cnt_reg <= '0;
      trunc_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      byte_cnt_reg <= byte_cnt_next;
      trunc_reg    <= trunc_next;
    end
  end

  assign grant_q     = 3'(grant_reg);
  assign busy        = (state_reg != IDLE);
  assign trunc_pulse = trunc_reg;

endmodule

// File: tb/tb_tsn_tx_frame_arbiter.sv
// Bench for tsn_tx_frame_arbiter: arbitration vector table, directed corner
// sequences and a randomized run against a frame-level scoreboard model.
module tb_tsn_tx_frame_arbiter;
  localparam int NQ   = 4;
  localparam int MAXL = 1522;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NQ-1:0] gate;
  logic          mode;
  logic [2:0]    grant_q;
  logic          busy, trunc_pulse;

  always #5 clk = ~clk;

  tsn_tx_frame_arbiter_if #(.NUM_QUEUES(NQ)) bus ();

  tsn_tx_frame_arbiter #(.NUM_QUEUES(NQ), .MAX_FRAME_LEN(MAXL), .CNT_W(11)) dut (
    .tx_mac_aclk  (clk),
    .tx_mac_resetn(rst_n),
    .axis         (bus),
    .gate_open    (gate),
    .arb_mode     (mode),
    .grant_q      (grant_q),
    .busy         (busy),
    .trunc_pulse  (trunc_pulse)
  );

  // Source byte streams and the expected output per queue.
  logic [7:0] src_d [NQ][$];
  bit         src_l [NQ][$];
  logic [7:0] exp_d [NQ][$];
  bit         exp_l [NQ][$];
  bit         exp_u [NQ][$];
  int         done_q [$];

  int errors = 0, checks = 0;
  int model_rr = 0, model_grant = 0, arb_exp = 0;
  bit arb_pending = 0, expect_noreq = 0, expect_gap = 0, expect_trunc = 0;
  bit prev_busy = 0, beat_seen = 0, rand_knobs = 0;
  int valid_pct = 100, ready_pct = 100;
  int grant_events = 0, first_grant = -1, trunc_seen = 0, cur_len = 0;

  typedef struct {
    int       pre_q;
    bit       md;
    bit [3:0] vm;
    bit [3:0] gm;
    int       exp_g;
  } arb_vec_t;
  arb_vec_t vecs [9];

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input bit [NQ-1:0] r, input bit m, input int ptr);
    if (!m) begin
      for (int q = NQ - 1; q >= 0; q--) if (r[q]) return q;
    end else begin
      for (int k = 0; k < NQ; k++) if (r[(ptr + k) % NQ]) return (ptr + k) % NQ;
    end
    return -1;
  endfunction

  task automatic load_frame(input int q, input int len);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      src_d[q].push_back(b);
      src_l[q].push_back(i == len - 1);
      if (i < MAXL) begin
        exp_d[q].push_back(b);
        exp_l[q].push_back((i == len - 1) || (i == MAXL - 1));
        exp_u[q].push_back((len > MAXL) && (i == MAXL - 1));
      end
    end
  endtask

  task automatic drive_inputs();
    int k;
    for (int q = 0; q < NQ; q++) begin
      if (src_d[q].size() > 0 && $urandom_range(99) < valid_pct) begin
        bus.s_axis_tvalid[q]       = 1'b1;
        bus.s_axis_tdata[8*q +: 8] = src_d[q][0];
        bus.s_axis_tlast[q]        = src_l[q][0];
      end else begin
        bus.s_axis_tvalid[q]       = 1'b0;
        bus.s_axis_tdata[8*q +: 8] = 8'h00;
        bus.s_axis_tlast[q]        = 1'b0;
      end
    end
    bus.m_axis_tready = ($urandom_range(99) < ready_pct);
    if (rand_knobs) begin
      if ($urandom_range(99) < 5) begin
        k = $urandom_range(NQ - 1);
        gate[k] = ~gate[k];
      end
      if ($urandom_range(99) < 3) mode = ~mode;
    end
  endtask

  task automatic cycle();
    bit [NQ-1:0] req, pops, onehot;
    int g;
    @(negedge clk);
    if (arb_pending) begin
      chk_eq("arb_busy", int'(busy), 1);
      chk_eq("arb_grant", int'(grant_q), arb_exp);
      model_grant = arb_exp;
      arb_pending = 0;
    end
    if (expect_noreq) begin chk_eq("no_req_stays_idle", int'(busy), 0); expect_noreq = 0; end
    if (expect_gap)   begin chk_eq("interframe_gap", int'(busy), 0); expect_gap = 0; end
    chk_eq("trunc_pulse", int'(trunc_pulse), int'(expect_trunc));
    expect_trunc = 0;
    if (trunc_pulse) trunc_seen++;
    if (busy && !prev_busy) begin
      grant_events++;
      if (grant_events == 1) first_grant = int'(grant_q);
    end
    prev_busy = busy;
    beat_seen = 0;
    if (!busy) begin
      chk_eq("idle_m_tvalid", int'(bus.m_axis_tvalid), 0);
      chk_eq("idle_s_tready", int'(bus.s_axis_tready), 0);
      req = bus.s_axis_tvalid & gate;
      if (req != 0) begin
        arb_exp = pick(req, mode, model_rr);
        arb_pending = 1;
      end else expect_noreq = 1;
    end else begin
      onehot = NQ'(1) << model_grant;
      chk_eq("tready_other_queue", int'(bus.s_axis_tready & ~onehot), 0);
    end
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      beat_seen = 1;
      g = model_grant;
      chk_eq("beat_has_expected", int'(exp_d[g].size() > 0), 1);
      if (exp_d[g].size() > 0) begin
        cur_len++;
        chk_eq("data", int'(bus.m_axis_tdata), int'(exp_d[g][0]));
        chk_eq("tlast", int'(bus.m_axis_tlast), int'(exp_l[g][0]));
        if (exp_l[g][0]) begin
          chk_eq("tuser", int'(bus.m_axis_tuser), int'(exp_u[g][0]));
          done_q.push_back(g);
          model_rr = (g + 1) % NQ;
          $display("frame q=%0d bytes=%0d tuser=%0b", g, cur_len, bus.m_axis_tuser);
          cur_len = 0;
          if (exp_u[g][0]) expect_trunc = 1;
          else expect_gap = 1;
        end
        void'(exp_d[g].pop_front());
        void'(exp_l[g].pop_front());
        void'(exp_u[g].pop_front());
      end
    end
    pops = bus.s_axis_tvalid & bus.s_axis_tready;
    @(posedge clk);
    #1;
    for (int q = 0; q < NQ; q++) begin
      if (pops[q] && src_d[q].size() > 0) begin
        void'(src_d[q].pop_front());
        void'(src_l[q].pop_front());
      end
    end
    drive_inputs();
  endtask

  function automatic bit all_empty();
    for (int q = 0; q < NQ; q++) if (src_d[q].size() != 0 || exp_d[q].size() != 0) return 0;
    return 1;
  endfunction

  task automatic run_until_idle(input int max_cycles);
    bit done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      cycle();
      if (all_empty() && !busy && !arb_pending && !expect_gap && !expect_trunc) done = 1;
    end
    chk_eq("drain_within_budget", int'(done), 1);
  endtask

  task automatic reset_assert();
    rst_n = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      src_d[q].delete(); src_l[q].delete();
      exp_d[q].delete(); exp_l[q].delete(); exp_u[q].delete();
    end
    done_q.delete();
    model_rr = 0; model_grant = 0; cur_len = 0;
    arb_pending = 0; expect_noreq = 0; expect_gap = 0; expect_trunc = 0; prev_busy = 0;
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_inputs();
  endtask

  task automatic do_reset();
    reset_assert();
    reset_release();
  endtask

  initial begin
    int n, busy_cnt, t0;
    vecs[0] = '{-1, 1'b0, 4'b1001, 4'b1111, 3};
    vecs[1] = '{-1, 1'b0, 4'b0111, 4'b1011, 1};
    vecs[2] = '{-1, 1'b1, 4'b1010, 4'b1111, 1};
    vecs[3] = '{ 1, 1'b1, 4'b0011, 4'b1111, 0};
    vecs[4] = '{ 2, 1'b1, 4'b1001, 4'b1111, 3};
    vecs[5] = '{ 3, 1'b1, 4'b0110, 4'b1111, 1};
    vecs[6] = '{ 0, 1'b0, 4'b0101, 4'b1111, 2};
    vecs[7] = '{-1, 1'b0, 4'b0100, 4'b1011, -1};
    vecs[8] = '{ 2, 1'b1, 4'b0100, 4'b1111, 2};

    rst_n = 1'b1;
    gate = '0; mode = 1'b0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = '0; bus.s_axis_tlast = '0;
    bus.m_axis_tready = 1'b0;
    #1;
    reset_assert();
    repeat (2) @(posedge clk);
    #1;
    chk_eq("reset_busy", int'(busy), 0);
    chk_eq("reset_grant_q", int'(grant_q), 0);
    chk_eq("reset_trunc", int'(trunc_pulse), 0);
    chk_eq("reset_m_tvalid", int'(bus.m_axis_tvalid), 0);
    chk_eq("reset_s_tready", int'(bus.s_axis_tready), 0);
    reset_release();

    // Arbitration table: optional priming frame sets rr_ptr, then one grant is checked.
    foreach (vecs[i]) begin
      do_reset();
      gate = '1; mode = 1'b0;
      if (vecs[i].pre_q >= 0) begin
        load_frame(vecs[i].pre_q, 4);
        drive_inputs();
        run_until_idle(100);
      end
      grant_events = 0;
      gate = vecs[i].gm; mode = vecs[i].md;
      for (int q = 0; q < NQ; q++) if (vecs[i].vm[q]) load_frame(q, 4);
      drive_inputs();
      repeat (8) cycle();
      if (vecs[i].exp_g >= 0) begin
        chk_eq($sformatf("vec%0d_granted", i), int'(grant_events > 0), 1);
        chk_eq($sformatf("vec%0d_grant_q", i), first_grant, vecs[i].exp_g);
      end else begin
        chk_eq($sformatf("vec%0d_no_grant", i), grant_events, 0);
      end
      $display("vector %0d mode=%0b valid=%b gate=%b first_grant=%0d", i, vecs[i].md,
               vecs[i].vm, vecs[i].gm, first_grant);
    end

    // Strict priority: queue 3 wins over queue 0.
    do_reset();
    gate = '1; mode = 1'b0;
    load_frame(0, 64); load_frame(3, 64);
    drive_inputs();
    run_until_idle(500);
    chk_eq("strict_frames", done_q.size(), 2);
    if (done_q.size() == 2) begin
      chk_eq("strict_first", done_q[0], 3);
      chk_eq("strict_second", done_q[1], 0);
    end

    // Round-robin rotation over three frames per queue.
    do_reset();
    gate = '1; mode = 1'b1;
    for (int r = 0; r < 3; r++) for (int q = 0; q < NQ; q++) load_frame(q, 60);
    drive_inputs();
    run_until_idle(2000);
    chk_eq("rr_frames", done_q.size(), 12);
    foreach (done_q[i]) chk_eq($sformatf("rr_order%0d", i), done_q[i], i % NQ);

    // Closed gate blocks the only requester; opening it starts the frame two edges later.
    do_reset();
    gate = 4'b1011; mode = 1'b0;
    load_frame(2, 50);
    drive_inputs();
    busy_cnt = 0;
    repeat (100) begin
      cycle();
      if (busy) busy_cnt++;
    end
    chk_eq("gate_closed_busy_cycles", busy_cnt, 0);
    gate[2] = 1'b1;
    drive_inputs();
    n = 0;
    for (int i = 0; i < 10 && !beat_seen; i++) begin
      cycle();
      n++;
    end
    chk_eq("gate_open_latency", n, 2);
    run_until_idle(200);

    // Oversize frame is truncated and drained; the next frame is intact.
    do_reset();
    gate = '1; mode = 1'b0;
    t0 = trunc_seen;
    load_frame(1, 2000); load_frame(1, 10);
    drive_inputs();
    run_until_idle(5000);
    chk_eq("trunc_pulse_count", trunc_seen - t0, 1);
    chk_eq("trunc_frames", done_q.size(), 2);

    // Exact-max frame under 50% back-pressure.
    do_reset();
    gate = '1; mode = 1'b0; ready_pct = 50;
    t0 = trunc_seen;
    load_frame(2, MAXL);
    drive_inputs();
    run_until_idle(10000);
    chk_eq("maxlen_no_trunc", trunc_seen - t0, 0);
    chk_eq("maxlen_frames", done_q.size(), 1);
    ready_pct = 100;

    // Reset while byte 30 is on the bus.
    do_reset();
    gate = '1; mode = 1'b0;
    load_frame(0, 100);
    drive_inputs();
    for (int i = 0; i < 200 && exp_d[0].size() > 71; i++) cycle();
    chk_eq("reset_point_reached", exp_d[0].size(), 71);
    rst_n = 1'b0;
    #1;
    chk_eq("midreset_busy", int'(busy), 0);
    chk_eq("midreset_m_tvalid", int'(bus.m_axis_tvalid), 0);
    chk_eq("midreset_m_tlast", int'(bus.m_axis_tlast), 0);
    chk_eq("midreset_m_tuser", int'(bus.m_axis_tuser), 0);
    chk_eq("midreset_s_tready", int'(bus.s_axis_tready), 0);
    chk_eq("midreset_grant_q", int'(grant_q), 0);
    reset_assert();
    reset_release();
    load_frame(0, 20);
    drive_inputs();
    run_until_idle(200);
    chk_eq("post_reset_frames", done_q.size(), 1);

    // Randomized traffic, gates and mode against the scoreboard.
    do_reset();
    gate = '1; mode = 1'b0;
    rand_knobs = 1; valid_pct = 80; ready_pct = 70;
    for (int f = 0; f < 40; f++) begin
      load_frame($urandom_range(NQ - 1), $urandom_range(1, 80));
      repeat ($urandom_range(0, 30)) cycle();
    end
    rand_knobs = 0;
    gate = '1;
    run_until_idle(20000);
    chk_eq("random_frames", done_q.size(), 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
